// File: rtl/cordic_rotate.sv
// cordic_rotate: iterative rotation-mode CORDIC producing amp*cos(angle), amp*sin(angle) with ready/valid on both sides
module cordic_rotate #(
  parameter int DATA_WIDTH  = 12,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  amp_in,
  input  logic signed [ANGLE_WIDTH-1:0] angle_in,
  input  logic                          in_vld,
  output logic                          in_rdy,
  output logic signed [DATA_WIDTH-1:0]  cos_out,
  output logic signed [DATA_WIDTH-1:0]  sin_out,
  output logic                          out_vld,
  input  logic                          out_rdy
);
  localparam int XW = DATA_WIDTH + 2;
  localparam int AW = ANGLE_WIDTH + 1;
  localparam logic signed [AW-1:0] FULL = AW'(23040);
  localparam logic signed [AW-1:0] HALF = AW'(11520);
  localparam logic signed [AW-1:0] QTR  = AW'(5760);
  localparam logic signed [13:0] GAIN = 14'sd2487;
  localparam logic signed [XW-1:0] SMAX = XW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SMIN = -SMAX - XW'(1);
  localparam int ATAN [0:11] = '{2880, 1700, 898, 456, 228, 114, 57, 28, 14, 7, 3, 1};

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  state_t r_state, w_next;
  logic signed [DATA_WIDTH-1:0]  r_amp;
  logic signed [ANGLE_WIDTH-1:0] r_angle;
  logic signed [XW-1:0]          r_x, r_y;
  logic signed [ANGLE_WIDTH-1:0] r_z;
  logic [3:0]                    r_cnt;
  logic signed [DATA_WIDTH-1:0]  r_cos, r_sin;
  logic                          r_vld;

  logic signed [AW-1:0]            w_a, w_wrap;
  logic signed [DATA_WIDTH+13:0]   w_prod;
  logic signed [XW-1:0]            w_amp_s, w_x0, w_xs, w_ys, w_xn, w_yn;
  logic signed [ANGLE_WIDTH-1:0]   w_z0, w_tab, w_zn;
  logic                            w_pos, w_last;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    return v > SMAX ? DATA_WIDTH'(SMAX) : v < SMIN ? DATA_WIDTH'(SMIN) : DATA_WIDTH'(v);
  endfunction

  assign in_rdy  = r_state == IDLE;
  assign cos_out = r_cos;
  assign sin_out = r_sin;
  assign out_vld = r_vld;

  // wrap the angle into +-180 deg, prescale by 1/K and fold the outer quadrants onto the inner ones
  always_comb begin
    w_a     = AW'(r_angle);
    w_wrap  = w_a > HALF ? w_a - FULL : w_a < -HALF ? w_a + FULL : w_a;
    w_prod  = r_amp * GAIN;
    w_amp_s = XW'(w_prod >>> 12);
    w_x0    = (w_wrap > QTR || w_wrap < -QTR) ? -w_amp_s : w_amp_s;
    w_z0    = ANGLE_WIDTH'(w_wrap > QTR ? w_wrap - HALF : w_wrap < -QTR ? w_wrap + HALF : w_wrap);
  end

  // one micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    w_xs   = r_x >>> r_cnt;
    w_ys   = r_y >>> r_cnt;
    w_tab  = ANGLE_WIDTH'(ATAN[r_cnt]);
    w_pos  = !r_z[ANGLE_WIDTH-1];
    w_xn   = w_pos ? r_x - w_ys : r_x + w_ys;
    w_yn   = w_pos ? r_y + w_xs : r_y - w_xs;
    w_zn   = w_pos ? r_z - w_tab : r_z + w_tab;
    w_last = r_cnt == 4'(ITERATIONS - 1);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_vld ? PRE : IDLE;
      PRE:     w_next = ITER;
      ITER:    w_next = w_last ? DONE : ITER;
      DONE:    w_next = out_rdy ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // datapath: capture, initial load, iterate, and hold the result until it is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_amp   <= '0;
      r_angle <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_vld   <= 1'b0;
    end else
      case (r_state)
        IDLE: if (in_vld) begin
          r_amp   <= amp_in;
          r_angle <= angle_in;
        end
        PRE: begin
          r_x   <= w_x0;
          r_y   <= '0;
          r_z   <= w_z0;
          r_cnt <= '0;
        end
        ITER: begin
          r_x   <= w_xn;
          r_y   <= w_yn;
          r_z   <= w_zn;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_cos <= sat(w_xn);
            r_sin <= sat(w_yn);
            r_vld <= 1'b1;
          end
        end
        DONE: if (out_rdy) r_vld <= 1'b0;
        default: ;
      endcase
endmodule

// File: tb/tb_cordic_rotate.sv
// tb_cordic_rotate: directed vectors with a queue scoreboard and a decoupled output monitor
module tb_cordic_rotate;
  logic clk = 1'b0, rst_n = 1'b0;
  logic signed [11:0] amp_in = '0;
  logic signed [15:0] angle_in = '0;
  logic in_vld = 1'b0, out_rdy = 1'b1;
  logic in_rdy, out_vld;
  logic signed [11:0] cos_out, sin_out;

  cordic_rotate dut (
    .clk(clk), .rst_n(rst_n), .amp_in(amp_in), .angle_in(angle_in), .in_vld(in_vld),
    .in_rdy(in_rdy), .cos_out(cos_out), .sin_out(sin_out), .out_vld(out_vld), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cl; int ch; int sl; int sh; int acc; string name;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;

  task automatic chk(string nm, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, want [%0d,%0d]", nm, act, lo, hi);
    end
  endtask

  // monitor: latency on rising out_vld, values on handshake, one-cycle valid and ready afterwards
  initial begin
    bit prev_vld, prev_hs;
    prev_vld = 0;
    prev_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 0;
        prev_hs = 0;
      end else begin
        if (prev_hs) begin
          chk("vld_drop", int'(out_vld), 0, 0);
          chk("rdy_after_hs", int'(in_rdy), 1, 1);
        end
        if (out_vld && !prev_vld && sb.size() != 0)
          chk({sb[0].name, "_latency"}, cyc - sb[0].acc, 13, 13);
        if (out_vld && out_rdy) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: cos=%0d sin=%0d, want no output", cos_out, sin_out);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_cos"}, int'(cos_out), e.cl, e.ch);
            chk({e.name, "_sin"}, int'(sin_out), e.sl, e.sh);
          end
        end
        prev_hs = out_vld && out_rdy;
        prev_vld = out_vld;
      end
    end
  end

  task automatic send(string nm, int amp, int ang, int cl, int ch, int sl, int sh, bit push);
    int t = 0;
    @(negedge clk);
    while (!in_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) begin
      checks++;
      failures++;
      $display("FAIL %s_rdy_timeout: in_rdy=0, want 1", nm);
      return;
    end
    amp_in = 12'(amp);
    angle_in = 16'(ang);
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    if (push) sb.push_back('{cl, ch, sl, sh, cyc, nm});
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int c0, s0, t;
    repeat (3) @(negedge clk);
    chk("rst_cos", int'(cos_out), 0, 0);
    chk("rst_sin", int'(sin_out), 0, 0);
    chk("rst_vld", int'(out_vld), 0, 0);
    chk("rst_rdy", int'(in_rdy), 1, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send("a0",      1000,      0,   996, 1004,    -4,    4, 1);
    send("a90",     1000,   5760,    -4,    4,   996, 1004, 1);
    send("a180",    1000,  11520, -1004, -996,    -4,    4, 1);
    send("am45",    1000,  -2880,   703,  711,  -711, -703, 1);
    send("w270",    1000,  17280,    -4,    4, -1004, -996, 1);
    send("wm270",   1000, -17280,    -4,    4,   996, 1004, 1);
    send("max0",    2047,      0,  2043, 2047,    -8,    8, 1);
    send("min180", -2048,  11520,  2043, 2047,    -8,    8, 1);
    drain();

    @(posedge clk);
    #1 out_rdy = 1'b0;
    send("bp", 1000, 2880, 703, 711, 703, 711, 1);
    t = 0;
    while (!out_vld && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("bp_vld_seen", int'(out_vld), 1, 1);
    c0 = int'(cos_out);
    s0 = int'(sin_out);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_vld = i[0];
      amp_in = 12'(i * 50);
      angle_in = 16'(i * 300);
      @(negedge clk);
      chk("bp_hold_vld", int'(out_vld), 1, 1);
      chk("bp_rdy_low", int'(in_rdy), 0, 0);
      chk("bp_cos_stable", int'(cos_out), c0, c0);
      chk("bp_sin_stable", int'(sin_out), s0, s0);
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    drain();
    repeat (20) @(negedge clk);

    send("abort", 1000, 0, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cos", int'(cos_out), 0, 0);
    chk("mid_rst_sin", int'(sin_out), 0, 0);
    chk("mid_rst_vld", int'(out_vld), 0, 0);
    chk("mid_rst_rdy", int'(in_rdy), 1, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send("post_rst", 500, 2880, 350, 358, 350, 358, 1);
    drain();
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_rotate.md
# cordic_rotate

Iterative rotation-mode CORDIC. It takes an amplitude and an angle in degrees ×64 and returns amplitude·cos(angle) and amplitude·sin(angle). It is the inverse of the vectoring-mode arctangent block: the same ×64 angle encoding and arctan table, with the rotation running in the other direction. It sits in the synthesis/re-modulation path, and a ready/valid handshake on both sides lets it sit between streaming stages.

## Interface
- DATA_WIDTH, 12, signed width of the amplitude input and of the cos/sin outputs
- ANGLE_WIDTH, 16, signed width of the angle input (degrees ×64)
- ITERATIONS, 12, number of CORDIC micro-rotations (maximum 12)
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- amp_in  in  DATA_WIDTH  signed amplitude
- angle_in  in  ANGLE_WIDTH  signed angle, degrees ×64
- in_vld  in  1  input valid
- in_rdy  out  1  input ready; equals (state==IDLE)
- cos_out  out  DATA_WIDTH  signed amplitude·cos(angle)
- sin_out  out  DATA_WIDTH  signed amplitude·sin(angle)
- out_vld  out  1  output valid
- out_rdy  in  1  downstream ready

## Operation
- Reset: clk and rst_n only, asynchronous active-low.
  - State goes to IDLE.
  - cos_out=0, sin_out=0, out_vld=0, all internal registers 0.
  - in_rdy=1 while in reset and after release.
- FSM states and transitions:
  - IDLE: in_vld&in_rdy → PRE, and amp_in/angle_in are captured.
  - PRE: → ITER after 1 cycle.
  - ITER: → DONE when the iteration counter reaches ITERATIONS-1.
  - DONE: out_vld&out_rdy → IDLE.
- Angle wrap, applied in PRE before quadrant mapping:
  - If a > 11520, a -= 23040.
  - If a < -11520, a += 23040.
  - One wrap covers the full 16-bit range.
- Gain prescale, in PRE: A = (amp·2487) >>> 12.
  - 2487 is 1/1.646760 in Q12.
  - Arithmetic shift, floor rounding.
- Quadrant mapping, in PRE. Internal x, y are DATA_WIDTH+2 bits signed; z is ANGLE_WIDTH bits signed.
  - a > 5760: x=-A, y=0, z=a-11520.
  - a < -5760: x=-A, y=0, z=a+11520.
  - Otherwise: x=A, y=0, z=a.
- Arctan table, degrees ×64 truncated, constant: 2880, 1700, 898, 456, 228, 114, 57, 28, 14, 7, 3, 1.
- ITER step i = 0..ITERATIONS-1, one step per cycle, all shifts arithmetic:
  - z ≥ 0: x -= y>>>i, y += x>>>i, z -= tab[i].
  - z < 0: x += y>>>i, y -= x>>>i, z += tab[i].
  - Both updates use the old x and y.
- Output, on the last ITER edge:
  - cos_out = sat(x), sin_out = sat(y), where sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_vld is set to 1.
- DONE holds the output:
  - cos_out, sin_out and out_vld stay stable until out_rdy=1.
  - On the handshake edge, out_vld is cleared. cos_out/sin_out keep their last value.
- in_rdy=0 in PRE, ITER and DONE. An in_vld asserted in those states is ignored; no data is taken.

## Timing
- Input handshake: accepted at the rising edge where in_vld=1 and in_rdy=1 (edge E0).
- PRE loads x/y/z at E1. Iterations run on E2..E(ITERATIONS+1).
- out_vld rises after edge E(ITERATIONS+1): 13 clocks after E0 with defaults.
- Output handshake: at edge D where out_vld&out_rdy, out_vld falls and state becomes IDLE. in_rdy is 1 in the following cycle.
- Throughput: at most one result per ITERATIONS+3 cycles. Inputs and outputs never overlap.
- out_rdy=1 held constant: DONE lasts exactly 1 cycle.
- rst_n asserted mid-operation: the result is aborted immediately. After release the block is in IDLE with out_vld=0, and no stale result is emitted.
- No combinational path from in_vld to in_rdy, or from out_rdy to out_vld.

## Test plan
- Angle 0: amp=1000, angle=0, out_rdy=1 → cos=1000±4, sin=0±4, out_vld 13 cycles after accept, high for 1 cycle.
- Quadrant boundaries, amp=1000:
  - angle=5760 → cos 0±4, sin 1000±4.
  - angle=11520 → cos -1000±4, sin 0±4.
  - angle=-2880 → cos 707±4, sin -707±4.
- Wrap: amp=1000, angle=17280 (270°) → cos 0±4, sin -1000±4. angle=-17280 → cos 0±4, sin 1000±4.
- Extremes: amp=2047, angle=0 → cos in [2043,2047]. amp=-2048, angle=11520 → cos in [2043,2047] (saturated, no wrap).
- Backpressure: out_rdy=0 for 20 cycles after out_vld → outputs stable, in_rdy=0, in_vld pulses ignored. Then out_rdy=1 → one handshake, in_rdy=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 at the 5th ITER cycle → all outputs 0, in_rdy=1. A new input (amp=500, angle=2880) after release → cos 354±4, sin 354±4.
